// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and instruction fetch sequencer
//
// Owns the PC and fetches one instruction at a time from instruction memory
// with a req/ack handshake. It presents each instruction to the datapath and
// then picks the next PC from the jump, branch or sequential source.
//
// Parameters:
//   RESET_VECTOR  PC value loaded on reset
//   MAX_WAIT      number of consecutive un-acked fetch cycles before the
//                 sequencer enters ERROR; 0 disables the timeout
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   imem_req / imem_addr       fetch request and address (address equals pc)
//   imem_ack / imem_rdata      fetch completion and instruction word
//   instr / instr_valid        registered instruction presented to datapath
//   stall                      datapath not ready; hold the current instruction
//   branch_taken/branch_target conditional redirect
//   jump / jump_target         unconditional redirect (wins over branch)
//   halt                       stop after the current instruction
//   pc                         current program counter
//   halted / fetch_err         sticky stop / fetch-timeout status

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] next_pc;

    // Redirect targets are forced word-aligned; sequential flow wraps naturally.
    always_comb begin
        next_pc = pc_q + 32'd4;
        if (jump) begin
            next_pc = jump_target & 32'hFFFF_FFFC;
        end else if (branch_taken) begin
            next_pc = branch_target & 32'hFFFF_FFFC;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    wait_d  = 32'd0;
                    state_d = S_ISSUE;
                end else begin
                    wait_d = wait_q + 32'd1;
                    // wait_q counts completed un-acked cycles, so this is the
                    // MAX_WAIT-th one; an ack in this same cycle still wins.
                    if ((MAX_WAIT != 0) && (wait_q == MAX_WAIT - 32'd1)) begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= 32'd0;
            wait_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    // Status outputs decode straight from the state register so that an
    // asynchronous reset drops imem_req and the others without a clock edge.
    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_ISSUE);
    assign halted      = (state_q == S_HALT);
    assign fetch_err   = (state_q == S_ERROR);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized self-checking bench for pc_sequencer

module tb_pc_sequencer;

    localparam int unsigned MAXW = 3;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] pc;
    logic        halted;
    logic        fetch_err;

    pc_sequencer #(.RESET_VECTOR(RV), .MAX_WAIT(MAXW)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc            (pc),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: what the sequencer is doing, in terms of visible behaviour.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_req;
    bit          m_valid;
    bit          m_halted;
    bit          m_err;
    int          m_misses;

    logic [31:0] addr_q[$];
    logic [31:0] want;
    bit          wchk;
    int          stage;
    int          stall_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc     = RV;
        m_instr  = 32'd0;
        m_req    = 0;
        m_valid  = 0;
        m_halted = 0;
        m_err    = 0;
        m_misses = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_halted || m_err) begin
            // stopped until reset
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr  = imem_rdata;
                m_req    = 0;
                m_valid  = 1;
                m_misses = 0;
            end else begin
                m_misses++;
                if (MAXW != 0 && m_misses == int'(MAXW)) begin
                    m_req = 0;
                    m_err = 1;
                end
            end
        end else if (m_valid) begin
            if (!stall) begin
                m_valid = 0;
                if (halt) begin
                    m_halted = 1;
                end else begin
                    if (jump)              m_pc = {jump_target[31:2], 2'b00};
                    else if (branch_taken) m_pc = {branch_target[31:2], 2'b00};
                    else                   m_pc = m_pc + 32'd4;
                    m_req = 1;
                end
            end
        end else begin
            m_req = 1;
        end
    endtask

    task automatic check_all();
        chk("imem_req",    {31'd0, imem_req},    {31'd0, m_req});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("pc",          pc,                   m_pc);
        chk("instr",       instr,                m_instr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("halted",      {31'd0, halted},      {31'd0, m_halted});
        chk("fetch_err",   {31'd0, fetch_err},   {31'd0, m_err});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        stall         = 1'b0;
        halt          = 1'b0;
        jump          = 1'b0;
        jump_target   = 32'd0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        quiet();
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst = 1'b0;

        // Straight-line fetch with immediate acks
        for (int i = 0; i < 8; i++) begin
            quiet();
            imem_ack   = 1'b1;
            imem_rdata = m_pc ^ 32'hA5A5_0000;
            tick();
            if (m_req) addr_q.push_back(imem_addr);
        end
        chk("addr_count", addr_q.size(), 32'd4);
        for (int k = 0; k < 4 && k < addr_q.size(); k++) begin
            chk("addr_seq", addr_q[k], 32'(k * 4));
        end

        // Reset between edges while a fetch is outstanding
        quiet();
        tick();
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_req",   {31'd0, imem_req}, 32'd0);
        chk("async_pc",    pc, RV);
        chk("async_instr", instr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("restart_addr", imem_addr, RV);

        // Redirects, wrap-around, stall, then halt
        stage   = 0;
        stall_n = 0;
        for (int i = 0; i < 80; i++) begin
            wchk          = 0;
            want          = 32'd0;
            quiet();
            imem_ack      = 1'b1;
            imem_rdata    = m_pc ^ 32'hA5A5_0000;
            jump_target   = $urandom;
            branch_target = $urandom;
            case (stage)
                0: if (m_valid && m_pc == 32'h8) begin
                    jump = 1'b1; jump_target = 32'h100;
                    branch_taken = 1'b1; branch_target = 32'h200;
                    want = 32'h100; wchk = 1; stage = 1;
                end
                1: if (m_valid && m_pc == 32'h100) begin
                    branch_taken = 1'b1; branch_target = 32'h203;
                    want = 32'h200; wchk = 1; stage = 2;
                end
                2: if (m_valid && m_pc == 32'h200) begin
                    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
                    want = 32'hFFFF_FFFC; wchk = 1; stage = 3;
                end
                3: if (m_valid && m_pc == 32'hFFFF_FFFC) begin
                    want = 32'h0; wchk = 1; stage = 4;
                end
                4: if (m_valid && m_pc == 32'h0) begin
                    if (stall_n < 3) begin
                        stall = 1'b1; halt = 1'b1; jump = 1'b1;
                        stall_n++;
                        want = 32'h0; wchk = 1;
                    end else begin
                        want = 32'h4; wchk = 1; stage = 5;
                    end
                end
                5: if (m_valid && m_pc == 32'h4) begin
                    halt = 1'b1; jump = 1'b1; jump_target = 32'h40;
                    want = 32'h4; wchk = 1; stage = 6;
                end
                default: begin
                    imem_ack     = 1'($urandom_range(0, 1));
                    halt         = 1'($urandom_range(0, 1));
                    jump         = 1'($urandom_range(0, 1));
                    stall        = 1'($urandom_range(0, 1));
                    branch_taken = 1'($urandom_range(0, 1));
                    imem_rdata   = $urandom;
                end
            endcase
            tick();
            if (wchk) chk("redirect_pc", pc, want);
        end
        chk("halt_stage",   32'(stage), 32'd6);
        chk("halt_flag",    {31'd0, halted}, 32'd1);
        chk("halt_pc",      pc, 32'h4);
        chk("halt_req_low", {31'd0, imem_req}, 32'd0);

        // Timeout: no ack at all
        do_reset();
        quiet();
        tick();
        for (int i = 0; i < 3; i++) begin
            quiet();
            tick();
        end
        chk("timeout_err", {31'd0, fetch_err}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            quiet();
            imem_ack = 1'($urandom_range(0, 1));
            halt     = 1'($urandom_range(0, 1));
            tick();
        end
        chk("timeout_sticky", {31'd0, fetch_err}, 32'd1);
        chk("timeout_req",    {31'd0, imem_req},  32'd0);

        // Timeout boundary: ack in the last allowed cycle
        do_reset();
        quiet();
        tick();
        quiet();
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd1);
        chk("late_ack_err",   {31'd0, fetch_err},   32'd0);
        chk("late_ack_instr", instr, 32'hCAFE_F00D);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            quiet();
            imem_ack      = ($urandom_range(0, 3) != 0);
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 2) == 0);
            halt          = ($urandom_range(0, 39) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            jump_target   = $urandom;
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = $urandom;
            if ((m_halted || m_err) && $urandom_range(0, 3) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer that owns the program counter and drives instruction fetch for the single-cycle core. It issues fetch requests to instruction memory with a req/ack handshake, presents each fetched instruction to the datapath, and selects the next PC from sequential, branch, or jump sources. It supports stall, halt, and a fetch-timeout error. It sits between instruction memory and the decode/execute datapath.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- MAX_WAIT, 15, consecutive un-acked FETCH cycles before error; 0 disables the timeout

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  memory has data; sampled only while imem_req=1
- imem_rdata  in  32  instruction word; valid when imem_ack=1
- instr  out  32  registered instruction for the datapath
- instr_valid  out  1  instr is valid and awaiting consumption
- stall  in  1  datapath not ready; hold the current instruction
- branch_taken  in  1  conditional redirect request
- branch_target  in  32  branch destination
- jump  in  1  unconditional redirect request
- jump_target  in  32  jump destination
- halt  in  1  stop fetching after the current instruction
- pc  out  32  current program counter (registered)
- halted  out  1  sequencer is stopped
- fetch_err  out  1  fetch timeout occurred (sticky)

## Operation
- States: IDLE, FETCH, ISSUE, HALT, ERROR.
- Reset values:
  - state=IDLE, pc=RESET_VECTOR, instr=0
  - imem_req=0, instr_valid=0, halted=0, fetch_err=0
  - wait counter=0
- IDLE: move unconditionally to FETCH on the next edge.
- FETCH: imem_req=1, and imem_addr=pc is held stable.
  - imem_ack=1: instr<=imem_rdata, go to ISSUE, clear the wait counter.
  - No ack: increment the wait counter.
  - MAX_WAIT>0 and counter==MAX_WAIT-1 with no ack: go to ERROR.
- ISSUE: instr_valid=1 and imem_req=0.
  - stall=1: hold everything; instr, pc, and state are unchanged.
  - stall=0 and halt=1: go to HALT; pc is unchanged.
  - stall=0 and halt=0: pc<=next, then go to FETCH.
  - Next-PC priority: jump → jump_target; else branch_taken → branch_target; else pc+4.
- Next-PC rules:
  - Target bits [1:0] are forced to 0.
  - pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
- HALT: halted=1, imem_req=0, instr_valid=0. Exit only by reset.
- ERROR: fetch_err=1, imem_req=0, instr_valid=0. Exit only by reset.
- Input gating:
  - stall, halt, jump, and branch_taken are ignored outside ISSUE.
  - imem_ack is ignored outside FETCH.
- Reset mid-operation: asserting rst in any state forces all reset values immediately, without waiting for a clock edge. An outstanding fetch is abandoned: imem_req drops asynchronously.

## Timing
- imem_req rises 1 cycle after reset deassertion (the IDLE cycle).
- Fetch latency: an ack in FETCH cycle k makes instr_valid=1 in cycle k+1.
- Best-case throughput: one instruction per 2 cycles (FETCH with same-cycle ack, then ISSUE).
- The pc update and the FETCH entry occur on the same edge. The new imem_addr is visible in the first FETCH cycle.
- instr_valid is high only in ISSUE. It drops on the edge that leaves ISSUE.
- Timeout: with MAX_WAIT=N and no ack, ERROR is entered on the edge ending the Nth FETCH cycle. An ack in the Nth cycle is accepted normally.
- All outputs are registered or decoded from registered state. There is no combinational path from an input to imem_req, instr_valid, or pc.

## Test plan
- Reset, then ack every FETCH cycle with rdata=pc^32'hA5A5_0000, no stall:
  - imem_addr sequence is 0, 4, 8, 12.
  - instr_valid pulses every other cycle with the matching instr.
  - All outputs are 0 during reset.
- Redirect in ISSUE at pc=8:
  - jump=1 (jump_target=32'h100) together with branch_taken=1 (branch_target=32'h200): next imem_addr=32'h100.
  - Next, branch_taken alone with target 32'h203: next imem_addr=32'h200.
- Wrap-around and stall:
  - Jump to 32'hFFFF_FFFC, then advance: next pc=0.
  - stall=1 for 3 cycles in ISSUE: instr_valid stays 1, and pc and instr are unchanged for those cycles.
- Timeout with MAX_WAIT=3:
  - No ack: fetch_err=1 after 3 FETCH cycles, imem_req=0, and it stays sticky.
  - Repeat with ack in the 3rd cycle: normal ISSUE, fetch_err=0.
- Halt: halt=1 together with jump=1 in ISSUE at pc=4:
  - halted=1 next cycle, pc stays 4, imem_req stays 0 thereafter.
  - Changes on halt, jump, and ack inputs have no effect.
- Reset mid-fetch: assert rst between edges while imem_req=1:
  - imem_req=0 and pc=RESET_VECTOR immediately.
  - After release, the fetch restarts at RESET_VECTOR following the IDLE cycle.
